// File: rtl/acsp_meta_responder.sv
// ACSP device-side reply generator.
// Accepts decoded opcodes from the command decoder and streams the reply
// bytes (ID query or tagged metadata) to uart_tx over a valid/ready byte
// handshake. A 0x00 opcode received mid-reply stops the reply once the byte
// currently on the bus has been accepted.
module acsp_meta_responder #(
  parameter int                    NAME_LEN         = 4,
  parameter logic [8*NAME_LEN-1:0] DEVICE_NAME      = "ACSP",
  parameter int                    FW_LEN           = 4,
  parameter logic [8*FW_LEN-1:0]   FW_VERSION       = "v1.0",
  parameter logic [31:0]           NUM_PROBES       = 32'd8,
  parameter logic [31:0]           SAMPLE_MEM_BYTES = 32'd4096,
  parameter logic [31:0]           MAX_SAMPLE_RATE  = 32'd100000000,
  parameter logic [31:0]           PROTOCOL_VER     = 32'd2
) (
  input  logic       system_clock,
  input  logic       ext_reset_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_opcode,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] OP_ABORT = 8'h00;
  localparam logic [7:0] OP_META  = 8'h02;
  localparam logic [7:0] OP_ID    = 8'h04;

  localparam int ID_LEN   = 4;
  localparam int META_LEN = NAME_LEN + FW_LEN + 25;
  localparam int IDX_W    = $clog2(META_LEN);

  // Both replies are fixed at elaboration time, so they live in constant
  // vectors with the first byte sent in the most significant position.
  localparam logic [8*ID_LEN-1:0] ID_STREAM = 32'h3141_4C53;

  localparam logic [8*META_LEN-1:0] META_STREAM = {
    8'h01, DEVICE_NAME, 8'h00,
    8'h02, FW_VERSION,  8'h00,
    8'h20, NUM_PROBES,
    8'h21, SAMPLE_MEM_BYTES,
    8'h23, MAX_SAMPLE_RATE,
    8'h24, PROTOCOL_VER,
    8'h00
  };

  typedef enum logic [1:0] {
    IDLE,
    SEND_ID,
    SEND_META,
    FINISH
  } state_e;

  state_e           state_q;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             abort_q;
  logic [IDX_W-1:0] index_q;

  logic [IDX_W-1:0] index_d;
  logic [7:0]       next_byte_d;
  logic             last_byte_d;
  logic             abort_req_d;
  logic             stop_d;

  // Byte at position i of the ID reply.
  function automatic logic [7:0] id_byte(input logic [IDX_W-1:0] i);
    logic [8*ID_LEN-1:0] shifted;
    shifted = ID_STREAM << {i, 3'b000};
    return shifted[8*ID_LEN-1 -: 8];
  endfunction

  // Byte at position i of the metadata reply.
  function automatic logic [7:0] meta_byte(input logic [IDX_W-1:0] i);
    logic [8*META_LEN-1:0] shifted;
    shifted = META_STREAM << {i, 3'b000};
    return shifted[8*META_LEN-1 -: 8];
  endfunction

  // Next byte to present, end-of-reply detection and abort decoding.
  always_comb begin
    // NOTE: every signal gets a default first so no path can leave it
    // unassigned and infer a latch.
    index_d     = index_q + 1'b1;
    next_byte_d = 8'h00;
    last_byte_d = 1'b0;
    abort_req_d = cmd_valid && (cmd_opcode == OP_ABORT) && busy_q;
    stop_d      = abort_q || abort_req_d;
    case (state_q)
      SEND_ID: begin
        next_byte_d = id_byte(index_d);
        last_byte_d = (index_q == IDX_W'(ID_LEN - 1));
      end
      SEND_META: begin
        next_byte_d = meta_byte(index_d);
        last_byte_d = (index_q == IDX_W'(META_LEN - 1));
      end
      default: ;
    endcase
  end

  // Reply FSM with registered handshake and status outputs.
  always_ff @(posedge system_clock or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      state_q    <= IDLE;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      index_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          index_q <= '0;
          abort_q <= 1'b0;
          if (cmd_valid && (cmd_opcode == OP_ID)) begin
            state_q    <= SEND_ID;
            tx_data_q  <= id_byte('0);
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
          end else if (cmd_valid && (cmd_opcode == OP_META)) begin
            state_q    <= SEND_META;
            tx_data_q  <= meta_byte('0);
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        SEND_ID, SEND_META: begin
          if (abort_req_d) begin
            abort_q <= 1'b1;
          end
          // The presented byte is never withdrawn; an abort only takes
          // effect once this byte has been accepted.
          if (tx_valid_q && tx_ready) begin
            if (last_byte_d || stop_d) begin
              tx_valid_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= FINISH;
            end else begin
              index_q   <= index_d;
              tx_data_q <= next_byte_d;
            end
          end
        end

        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          abort_q <= 1'b0;
          index_q <= '0;
        end

        default: begin
          state_q    <= IDLE;
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_acsp_meta_responder.sv
// Self-checking bench for acsp_meta_responder: drives opcodes and a
// randomized tx_ready, collects accepted bytes and compares them with the
// reply the protocol defines for each opcode.
module tb_acsp_meta_responder;

  localparam int           NAME_LEN    = 4;
  localparam logic [31:0]  DEVICE_NAME = "ACSP";
  localparam int           FW_LEN      = 4;
  localparam logic [31:0]  FW_VERSION  = "v1.0";
  localparam logic [31:0]  NUM_PROBES  = 32'd8;
  localparam logic [31:0]  SAMPLE_MEM  = 32'd4096;
  localparam logic [31:0]  MAX_RATE    = 32'd100000000;
  localparam logic [31:0]  PROTO_VER   = 32'd2;
  localparam int           CYCLE_LIMIT = 400;

  typedef logic [7:0] byte_q_t[$];

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic [7:0] cmd_opcode;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  acsp_meta_responder #(
    .NAME_LEN        (NAME_LEN),
    .DEVICE_NAME     (DEVICE_NAME),
    .FW_LEN          (FW_LEN),
    .FW_VERSION      (FW_VERSION),
    .NUM_PROBES      (NUM_PROBES),
    .SAMPLE_MEM_BYTES(SAMPLE_MEM),
    .MAX_SAMPLE_RATE (MAX_RATE),
    .PROTOCOL_VER    (PROTO_VER)
  ) dut (
    .system_clock(clk),
    .ext_reset_n (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_opcode  (cmd_opcode),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the reply defined for an opcode, built from the
  // protocol rules (tag, characters, terminators, 32-bit big-endian values).
  function automatic void push_str(inout byte_q_t q, input logic [127:0] s, input int len);
    for (int i = len - 1; i >= 0; i--) q.push_back(8'((s >> (8 * i)) & 128'hFF));
  endfunction

  function automatic void push_u32(inout byte_q_t q, input logic [31:0] v);
    for (int b = 3; b >= 0; b--) q.push_back(8'((v >> (8 * b)) & 32'hFF));
  endfunction

  function automatic byte_q_t model_reply(input logic [7:0] op);
    byte_q_t q;
    q = {};
    if (op == 8'h04) begin
      q = '{8'h31, 8'h41, 8'h4C, 8'h53};
    end else if (op == 8'h02) begin
      q.push_back(8'h01); push_str(q, 128'(DEVICE_NAME), NAME_LEN); q.push_back(8'h00);
      q.push_back(8'h02); push_str(q, 128'(FW_VERSION), FW_LEN);    q.push_back(8'h00);
      q.push_back(8'h20); push_u32(q, NUM_PROBES);
      q.push_back(8'h21); push_u32(q, SAMPLE_MEM);
      q.push_back(8'h23); push_u32(q, MAX_RATE);
      q.push_back(8'h24); push_u32(q, PROTO_VER);
      q.push_back(8'h00);
    end
    return q;
  endfunction

  // Issue one command and run the reply to completion.
  //   rand_ready : toggle tx_ready randomly (otherwise held high)
  //   stall_at   : when byte #stall_at is presented, hold tx_ready low for stall_len cycles
  //   ign_at     : while byte #ign_at is presented, send opcode 0x04 (must be ignored)
  //   abort_at   : while byte #abort_at is stalled, send opcode 0x00
  //   poke_tail  : send opcode 0x04 on the last transfer and during the done cycle
  task automatic run_reply(input string tag, input logic [7:0] op, input bit rand_ready,
                           input int stall_at, input int stall_len, input int ign_at,
                           input int abort_at, input bit poke_tail, input byte_q_t exp);
    byte_q_t    got;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    bit         pend_done  = 1'b0;
    bit         finished   = 1'b0;
    bit         stall_used = 1'b0;
    bit         ign_used   = 1'b0;
    bit         abort_used = 1'b0;
    int         stall_left = 0;
    int         cyc        = 0;

    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    tx_ready   = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, "_lat_valid"}, 32'(tx_valid), 32'd1);
    check({tag, "_lat_busy"},  32'(busy),     32'd1);

    while (!finished && cyc < CYCLE_LIMIT) begin
      cmd_valid = 1'b0;
      if (prev_stall) begin
        check({tag, "_stall_valid"}, 32'(tx_valid), 32'd1);
        check({tag, "_stall_data"},  32'(tx_data),  32'(prev_data));
      end
      prev_stall = 1'b0;
      if (pend_done) begin
        check({tag, "_done"},       32'(done),     32'd1);
        check({tag, "_done_busy"},  32'(busy),     32'd1);
        check({tag, "_done_valid"}, 32'(tx_valid), 32'd0);
        if (poke_tail) begin
          cmd_valid  = 1'b1;
          cmd_opcode = 8'h04;
        end
        finished = 1'b1;
      end else if (!tx_valid) begin
        check({tag, "_early_end"}, 32'(got.size()), 32'(exp.size()));
        break;
      end else begin
        if (stall_left > 0) begin
          tx_ready = 1'b0;
          stall_left--;
        end else if (!stall_used && got.size() == stall_at) begin
          stall_used = 1'b1;
          stall_left = stall_len - 1;
          tx_ready   = 1'b0;
        end else begin
          tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (!ign_used && got.size() == ign_at) begin
          ign_used   = 1'b1;
          cmd_valid  = 1'b1;
          cmd_opcode = 8'h04;
        end
        if (!abort_used && got.size() == abort_at && !tx_ready) begin
          abort_used = 1'b1;
          cmd_valid  = 1'b1;
          cmd_opcode = 8'h00;
        end
        check({tag, "_busy"}, 32'(busy), 32'd1);
        if (tx_ready) begin
          got.push_back(tx_data);
          if (got.size() == exp.size()) begin
            pend_done = 1'b1;
            if (poke_tail) begin
              cmd_valid  = 1'b1;
              cmd_opcode = 8'h04;
            end
          end
        end else begin
          prev_stall = 1'b1;
          prev_data  = tx_data;
        end
      end
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    tx_ready  = 1'b1;
    if (cyc >= CYCLE_LIMIT) check({tag, "_timeout"}, 32'd0, 32'd1);

    check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));

    // The cycle after the done pulse the block must be idle again.
    check({tag, "_post_done"},  32'(done),     32'd0);
    check({tag, "_post_busy"},  32'(busy),     32'd0);
    check({tag, "_post_valid"}, 32'(tx_valid), 32'd0);
  endtask

  task automatic expect_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      check({tag, "_idle_valid"}, 32'(tx_valid), 32'd0);
      check({tag, "_idle_busy"},  32'(busy),     32'd0);
    end
  endtask

  initial begin
    byte_q_t id_q;
    byte_q_t meta_q;
    byte_q_t part_q;

    id_q   = model_reply(8'h04);
    meta_q = model_reply(8'h02);

    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_opcode = 8'h00;
    tx_ready   = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_data",  32'(tx_data),  32'h00);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_busy",  32'(busy),     32'd0);
    check("rst_done",  32'(done),     32'd0);
    rst_n = 1'b1;

    // ID query at full rate, with commands on the last transfer and in FINISH.
    run_reply("id", 8'h04, 1'b0, -1, 0, -1, -1, 1'b1, id_q);
    expect_idle("id_tail", 4);

    // Unknown opcode while idle.
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_opcode = 8'h55;
    expect_idle("op55", 4);

    // Metadata at full rate.
    run_reply("meta", 8'h02, 1'b0, -1, 0, -1, -1, 1'b0, meta_q);

    // Metadata with random back-pressure and a 10-cycle stall mid-stream.
    run_reply("meta_bp", 8'h02, 1'b1, 15, 10, -1, -1, 1'b0, meta_q);

    // Abort while byte 0x76 is stalled; an ID opcode mid-reply is ignored.
    part_q = {};
    for (int i = 0; i < 8; i++) part_q.push_back(meta_q[i]);
    run_reply("abort", 8'h02, 1'b0, 7, 3, 4, 7, 1'b0, part_q);
    expect_idle("abort", 2);

    // Reset mid-reply while byte 12 is presented.
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_opcode = 8'h02;
    tx_ready   = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (11) @(negedge clk);
    check("mid_rst_byte12", 32'(tx_data), 32'(meta_q[11]));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_busy",  32'(busy),     32'd0);
    check("mid_rst_data",  32'(tx_data),  32'h00);
    check("mid_rst_done",  32'(done),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_idle("post_rst", 2);
    run_reply("id_after_rst", 8'h04, 1'b0, -1, 0, -1, -1, 1'b0, id_q);

    // Randomized queries with random back-pressure.
    for (int k = 0; k < 6; k++) begin
      logic [7:0] op;
      op = ($urandom_range(0, 1) != 0) ? 8'h02 : 8'h04;
      run_reply($sformatf("rnd%0d", k), op, 1'b1, -1, 0, -1, -1, 1'b0, model_reply(op));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
